elevator_call_scheduler: RTL

- Consumes the one-cycle debounced button pulses, one per floor call button, produced by the button controller stage.
- Latches the floor calls and runs the car-motion state machine using a SCAN policy: keep the current direction while calls remain ahead, otherwise reverse.
- Times floor-to-floor travel and door dwell with an internal cycle counter.
- Drives the floor display, direction/moving indicators, call lamps and door output.

---
 rtl/elevator_call_scheduler.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/elevator_call_scheduler.sv
// SCAN elevator call scheduler: latches floor calls and sequences IDLE/MOVE/DOOR with one shared cycle timer.
// Optional door hold input is compiled in when ELEVATOR_DOOR_HOLD_EN is defined.
module elevator_call_scheduler #(
    parameter int FLOORS        = 4,
    parameter int FLOOR_W       = 2,
    parameter int TRAVEL_CYCLES = 50_000_000,
    parameter int DOOR_CYCLES   = 100_000_000
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [FLOORS-1:0]  call_pulse,
`ifdef ELEVATOR_DOOR_HOLD_EN
    input  logic               door_hold,
`endif
    output logic [FLOOR_W-1:0] cur_floor,
    output logic [FLOORS-1:0]  pending,
    output logic               dir_up,
    output logic               moving,
    output logic               door_open,
    output logic               arrive
);

    localparam int MAX_CYC = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int TIMER_W = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;
    localparam logic [TIMER_W-1:0] TRAVEL_LAST = TIMER_W'(TRAVEL_CYCLES - 1);
    localparam logic [TIMER_W-1:0] DOOR_LAST   = TIMER_W'(DOOR_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MOVE = 2'd1,
        S_DOOR = 2'd2
    } state_t;

    state_t               r_state;
    logic [FLOOR_W-1:0]   r_floor;
    logic [FLOORS-1:0]    r_pending;
    logic                 r_dir_up;
    logic                 r_moving;
    logic                 r_door;
    logic                 r_arrive;
    logic [TIMER_W-1:0]   r_timer;

    state_t               w_state_nxt;
    logic [FLOOR_W-1:0]   w_floor_nxt;
    logic [FLOORS-1:0]    w_pend_nxt;
    logic                 w_dir_nxt;
    logic                 w_arrive_nxt;
    logic [TIMER_W-1:0]   w_timer_nxt;
    logic [FLOOR_W-1:0]   w_step_floor;
    logic                 w_above;
    logic                 w_below;
    logic                 w_here;
    logic                 w_hold;

    assign cur_floor = r_floor;
    assign pending   = r_pending;
    assign dir_up    = r_dir_up;
    assign moving    = r_moving;
    assign door_open = r_door;
    assign arrive    = r_arrive;

`ifdef ELEVATOR_DOOR_HOLD_EN
    assign w_hold = door_hold;
`else
    assign w_hold = 1'b0;
`endif

    assign w_here       = r_pending[r_floor] | call_pulse[r_floor];
    assign w_step_floor = r_dir_up ? (r_floor + FLOOR_W'(1)) : (r_floor - FLOOR_W'(1));

    always_comb begin
        w_above = 1'b0;
        w_below = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (r_pending[i] && (i > int'(r_floor))) w_above = 1'b1;
            if (r_pending[i] && (i < int'(r_floor))) w_below = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_floor_nxt  = r_floor;
        w_pend_nxt   = r_pending | call_pulse;
        w_dir_nxt    = r_dir_up;
        w_arrive_nxt = 1'b0;
        w_timer_nxt  = r_timer;

        unique case (r_state)
            S_IDLE: begin
                w_timer_nxt = '0;
                if (w_here) begin
                    w_state_nxt         = S_DOOR;
                    w_pend_nxt[r_floor] = 1'b0;
                end else if (r_dir_up && w_above) begin
                    w_state_nxt = S_MOVE;
                end else if (!r_dir_up && w_below) begin
                    w_state_nxt = S_MOVE;
                end else if (w_above) begin
                    w_dir_nxt   = 1'b1;
                    w_state_nxt = S_MOVE;
                end else if (w_below) begin
                    w_dir_nxt   = 1'b0;
                    w_state_nxt = S_MOVE;
                end
            end

            S_MOVE: begin
                if (r_timer == TRAVEL_LAST) begin
                    w_timer_nxt  = '0;
                    w_floor_nxt  = w_step_floor;
                    w_arrive_nxt = 1'b1;
                    // Stop test sees calls pressed in this very cycle for the floor being reached.
                    if (w_pend_nxt[w_step_floor]) begin
                        w_state_nxt              = S_DOOR;
                        w_pend_nxt[w_step_floor] = 1'b0;
                    end
                end else begin
                    w_timer_nxt = r_timer + TIMER_W'(1);
                end
            end

            S_DOOR: begin
                if (call_pulse[r_floor]) begin
                    w_timer_nxt         = '0;
                    w_pend_nxt[r_floor] = 1'b0;
                end else if (w_hold) begin
                    w_timer_nxt = '0;
                end else if (r_timer == DOOR_LAST) begin
                    w_timer_nxt = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_timer_nxt = r_timer + TIMER_W'(1);
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_timer_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_floor   <= '0;
            r_pending <= '0;
            r_dir_up  <= 1'b1;
            r_moving  <= 1'b0;
            r_door    <= 1'b0;
            r_arrive  <= 1'b0;
            r_timer   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_floor   <= w_floor_nxt;
            r_pending <= w_pend_nxt;
            r_dir_up  <= w_dir_nxt;
            r_moving  <= (w_state_nxt == S_MOVE);
            r_door    <= (w_state_nxt == S_DOOR);
            r_arrive  <= w_arrive_nxt;
            r_timer   <= w_timer_nxt;
        end
    end

    // SCAN keeps a call ahead of the car, so a step off either end of the shaft is a logic bug.
    always @(posedge clk) begin
        if (reset_n && (r_state == S_MOVE) && (r_timer == TRAVEL_LAST)) begin
            assert (r_dir_up ? (int'(r_floor) < FLOORS - 1) : (r_floor != '0));
            assert (r_dir_up ? w_above : w_below);
        end
    end

endmodule
